// File: rtl/ualink_input_arbiter.sv
// rtl/ualink_input_arbiter.sv - packet-granular round-robin merge of five AXI-Stream ingress ports
// Defining ARB_PKT_CNT_EN adds per-port 32-bit completed-packet counters (pkt_cnt_0..4).
module ualink_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 5
) (
    input  logic                              axi_aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic                              s_axis_tvalid_0,
    input  logic                              s_axis_tlast_0,
    output logic                              s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic                              s_axis_tvalid_1,
    input  logic                              s_axis_tlast_1,
    output logic                              s_axis_tready_1,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
    input  logic                              s_axis_tvalid_2,
    input  logic                              s_axis_tlast_2,
    output logic                              s_axis_tready_2,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
    input  logic                              s_axis_tvalid_3,
    input  logic                              s_axis_tlast_3,
    output logic                              s_axis_tready_3,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
    input  logic                              s_axis_tvalid_4,
    input  logic                              s_axis_tlast_4,
    output logic                              s_axis_tready_4,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [2:0]                        grant_port,
    output logic                              busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1,
    output logic [31:0]                       pkt_cnt_2,
    output logic [31:0]                       pkt_cnt_3,
    output logic [31:0]                       pkt_cnt_4
`endif
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t state, state_n;
    logic [2:0] rr_ptr, rr_n, grant_n, sel, idx;
    logic       found, xfer_last;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   s_tdata [NUM_PORTS];
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_tuser [NUM_PORTS];
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_tstrb [NUM_PORTS];
    logic [NUM_PORTS-1:0]             s_tvalid, s_tlast, s_tready;

    assign s_tdata = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4};
    assign s_tuser = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4};
    assign s_tstrb = '{s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4};
    assign s_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign s_tlast  = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

    assign s_axis_tready_0 = s_tready[0];
    assign s_axis_tready_1 = s_tready[1];
    assign s_axis_tready_2 = s_tready[2];
    assign s_axis_tready_3 = s_tready[3];
    assign s_axis_tready_4 = s_tready[4];

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // First requester at or after rr_ptr, wrapping around the port ring
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr;
        idx   = rr_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && s_tvalid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = next_port(idx);
        end
    end

    always_comb begin
        busy          = (state == PKT);
        m_axis_tdata  = s_tdata[grant_port];
        m_axis_tuser  = s_tuser[grant_port];
        m_axis_tstrb  = s_tstrb[grant_port];
        m_axis_tvalid = busy && s_tvalid[grant_port];
        m_axis_tlast  = busy && s_tlast[grant_port];
        s_tready      = '0;
        if (busy)
            s_tready[grant_port] = m_axis_tready;
        xfer_last     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end

    always_comb begin
        state_n = state;
        grant_n = grant_port;
        rr_n    = rr_ptr;
        case (state)
            IDLE: if (found) begin
                state_n = PKT;
                grant_n = sel;
            end
            PKT: if (xfer_last) begin
                state_n = IDLE;
                rr_n    = next_port(grant_port);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state      <= IDLE;
            grant_port <= 3'd0;
            rr_ptr     <= 3'd0;
        end else begin
            state      <= state_n;
            grant_port <= grant_n;
            rr_ptr     <= rr_n;
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt [NUM_PORTS];

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++)
                pkt_cnt[i] <= '0;
        end else if (xfer_last) begin
            pkt_cnt[grant_port] <= pkt_cnt[grant_port] + 32'd1;
        end
    end

    assign pkt_cnt_0 = pkt_cnt[0];
    assign pkt_cnt_1 = pkt_cnt[1];
    assign pkt_cnt_2 = pkt_cnt[2];
    assign pkt_cnt_3 = pkt_cnt[3];
    assign pkt_cnt_4 = pkt_cnt[4];
`endif

endmodule

// File: tb/tb_ualink_input_arbiter.sv
// tb/tb_ualink_input_arbiter.sv - directed self-checking bench for ualink_input_arbiter
module tb_ualink_input_arbiter;

    logic axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    logic         reset;
    logic [63:0]  s_tdata [5];
    logic [127:0] s_tuser [5];
    logic [7:0]   s_tstrb [5];
    logic         s_tvalid [5];
    logic         s_tlast [5];
    logic         s_tready [5];
    logic [63:0]  m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic [7:0]   m_axis_tstrb;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
    logic [2:0]   grant_port;
`ifdef ARB_PKT_CNT_EN
    logic [31:0]  pkt_cnt [5];
`endif

    ualink_input_arbiter dut (
        .axi_aclk(axi_aclk), .reset(reset),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tuser_0(s_tuser[0]), .s_axis_tstrb_0(s_tstrb[0]),
        .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tlast_0(s_tlast[0]), .s_axis_tready_0(s_tready[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tuser_1(s_tuser[1]), .s_axis_tstrb_1(s_tstrb[1]),
        .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tlast_1(s_tlast[1]), .s_axis_tready_1(s_tready[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tuser_2(s_tuser[2]), .s_axis_tstrb_2(s_tstrb[2]),
        .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tlast_2(s_tlast[2]), .s_axis_tready_2(s_tready[2]),
        .s_axis_tdata_3(s_tdata[3]), .s_axis_tuser_3(s_tuser[3]), .s_axis_tstrb_3(s_tstrb[3]),
        .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tlast_3(s_tlast[3]), .s_axis_tready_3(s_tready[3]),
        .s_axis_tdata_4(s_tdata[4]), .s_axis_tuser_4(s_tuser[4]), .s_axis_tstrb_4(s_tstrb[4]),
        .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tlast_4(s_tlast[4]), .s_axis_tready_4(s_tready[4]),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant_port(grant_port), .busy(busy)
`ifdef ARB_PKT_CNT_EN
        , .pkt_cnt_0(pkt_cnt[0]), .pkt_cnt_1(pkt_cnt[1]), .pkt_cnt_2(pkt_cnt[2]),
        .pkt_cnt_3(pkt_cnt[3]), .pkt_cnt_4(pkt_cnt[4])
`endif
    );

    int tests = 0, fails = 0;
    int npk [5], len [5], pkt [5], beat [5];
    int ord [$];
    int xfers = 0, dones = 0, cyc = 0, c, x0;
    bit toggle = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dat(input int p, input int k, input int b);
        return {8'hA0 + 8'(p), 8'(k), 16'(b), 32'hC0DE_0000 + 32'(b)};
    endfunction

    function automatic int ord_at(input int i);
        return (i < ord.size()) ? ord[i] : -1;
    endfunction

    task automatic drive();
        for (int p = 0; p < 5; p++) begin
            s_tvalid[p] = (npk[p] > 0);
            s_tdata[p]  = dat(p, pkt[p], beat[p]);
            s_tuser[p]  = {~dat(p, pkt[p], beat[p]), dat(p, pkt[p], beat[p])};
            s_tstrb[p]  = (beat[p] == len[p] - 1) ? 8'h0F : 8'hFF;
            s_tlast[p]  = (npk[p] > 0) && (beat[p] == len[p] - 1);
        end
    endtask

    task automatic enqueue(input int p, input int n, input int l);
        npk[p] = n; len[p] = l; beat[p] = 0;
        drive();
        #1;
    endtask

    // Observe the current cycle, clock it, then advance each source that handshook
    task automatic tick();
        bit hs [5];
        int g;
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            g = int'(grant_port);
            check("grant_range", g < 5, 1);
            if (g < 5) begin
                check("m_tdata", m_axis_tdata, dat(g, pkt[g], beat[g]));
                check("m_tuser", m_axis_tuser, {~dat(g, pkt[g], beat[g]), dat(g, pkt[g], beat[g])});
                check("m_tlast", m_axis_tlast, beat[g] == len[g] - 1);
                check("s_tready_grant", s_tready[g], 1);
                xfers++;
                if (m_axis_tlast) begin
                    dones++;
                    ord.push_back(g);
                end
            end
        end
        for (int p = 0; p < 5; p++) hs[p] = s_tvalid[p] && s_tready[p];
        @(posedge axi_aclk);
        #1;
        cyc++;
        for (int p = 0; p < 5; p++) begin
            if (hs[p]) begin
                beat[p]++;
                if (beat[p] == len[p]) begin
                    beat[p] = 0; pkt[p]++; npk[p]--;
                end
            end
        end
        m_axis_tready = toggle ? ((cyc % 2) == 1) : 1'b1;
        drive();
        #4;
    endtask

    task automatic run_until(input string tag, input int target, input int budget, output int n);
        n = 0;
        while (dones < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, dones >= target, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 5; p++) begin npk[p] = 0; len[p] = 0; beat[p] = 0; pkt[p] = 0; end
        drive();
        @(posedge axi_aclk);
        @(posedge axi_aclk);
        #1;
        reset = 1'b0;
        #4;
    endtask

    initial begin
        m_axis_tready = 1'b1;
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_grant", grant_port, 0);
        for (int p = 0; p < 5; p++) check("rst_tready", s_tready[p], 0);
        reset = 1'b0;
        @(posedge axi_aclk);
        #5;

        // Port 0, 16 beats: one bubble then 16 back-to-back beats
        enqueue(0, 1, 16);
        check("b_bubble_busy", busy, 0);
        check("b_bubble_tvalid", m_axis_tvalid, 0);
        check("b_bubble_tready", s_tready[0], 0);
        x0 = xfers;
        run_until("b", 1, 40, c);
        check("b_cycles", c, 17);
        check("b_xfers", xfers - x0, 16);
        check("b_idle_after", busy, 0);

        // Ports 0,2,4 simultaneously, 3 beats each
        do_reset();
        ord.delete(); dones = 0;
        enqueue(0, 1, 3); enqueue(2, 1, 3); enqueue(4, 1, 3);
        run_until("c", 3, 40, c);
        check("c_cycles", c, 12);
        check("c_ord0", ord_at(0), 0);
        check("c_ord1", ord_at(1), 2);
        check("c_ord2", ord_at(2), 4);
        // rr_ptr back at 0: port 0 wins over port 1; single-beat packets
        enqueue(0, 1, 1); enqueue(1, 1, 1);
        run_until("c2", 5, 20, c);
        check("c2_cycles", c, 4);
        check("c2_ord3", ord_at(3), 0);
        check("c2_ord4", ord_at(4), 1);

        // Port 3 requests while port 1 is mid-packet
        enqueue(1, 1, 6);
        for (int i = 0; i < 3; i++) tick();
        check("d_busy", busy, 1);
        check("d_grant", grant_port, 1);
        enqueue(3, 1, 2);
        c = 0;
        while (dones < 7 && c < 40) begin
            if (dones < 6) check("d_rdy3", s_tready[3], 0);
            tick();
            c++;
        end
        check("d_timeout", dones >= 7, 1);
        check("d_ord5", ord_at(5), 1);
        check("d_ord6", ord_at(6), 3);

        // Backpressure toggling during an 8-beat port 2 packet
        toggle = 1'b1;
        enqueue(2, 1, 8);
        x0 = xfers; c = 0;
        while (dones < 8 && c < 60) begin
            if (busy) check("e_rdy2", s_tready[2], m_axis_tready);
            tick();
            c++;
        end
        check("e_timeout", dones >= 8, 1);
        check("e_xfers", xfers - x0, 8);
        check("e_ord7", ord_at(7), 2);
        toggle = 1'b0;
        m_axis_tready = 1'b1;
        #1;

        // Reset pulse at beat 4 of a port 0 packet
        do_reset();
        ord.delete(); dones = 0;
        enqueue(0, 1, 10);
        for (int i = 0; i < 5; i++) tick();
        check("f_busy_pre", busy, 1);
        check("f_beat_pre", beat[0], 4);
        reset = 1'b1;
        @(posedge axi_aclk);
        #1;
        reset = 1'b0;
        npk[0] = 0; beat[0] = 0;
        drive();
        #4;
        check("f_busy", busy, 0);
        check("f_tvalid", m_axis_tvalid, 0);
        check("f_grant", grant_port, 0);
        enqueue(0, 1, 2);
        run_until("f", 1, 20, c);
        check("f_cycles", c, 3);
        check("f_ord0", ord_at(0), 0);

`ifdef ARB_PKT_CNT_EN
        do_reset();
        dones = 0;
        for (int p = 0; p < 5; p++) check("g_cnt_rst", pkt_cnt[p], 0);
        enqueue(4, 3, 2); enqueue(0, 1, 1);
        run_until("g", 4, 60, c);
        check("g_cnt0", pkt_cnt[0], 1);
        check("g_cnt1", pkt_cnt[1], 0);
        check("g_cnt2", pkt_cnt[2], 0);
        check("g_cnt3", pkt_cnt[3], 0);
        check("g_cnt4", pkt_cnt[4], 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
